// File: rtl/reg_lock_tracker.sv
// Register-lock scoreboard: merges issued lock vectors, releases locks on writeback,
// and tracks blocking instructions and the outstanding memory operation.
module reg_lock_tracker #(
    parameter int unsigned NR  = 64,
    parameter int unsigned NWB = 2
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             issue_valid_i,
    input  logic [NR-1:0]                    issue_locks_i,
    input  logic                             issue_mem_op_i,
    input  logic                             issue_blocking_i,
    input  logic [NWB-1:0]                   wb_valid_i,
    input  logic [NWB-1:0][$clog2(NR)-1:0]   wb_rd_i,
    input  logic                             mem_done_i,
    input  logic                             blk_done_i,
    input  logic                             flush_i,
    output logic [NR-1:0]                    locks_o,
    output logic                             mem_busy_o,
    output logic                             blocked_o,
    output logic [$clog2(NR):0]              lock_cnt_o,
    output logic                             err_o
);

    localparam int unsigned CW = $clog2(NR) + 1;

    typedef enum logic {IDLE, BLOCKED} state_t;

    state_t          state, state_nx;
    logic [NR-1:0]   lk, lk_nx;
    logic            mem_nx;
    logic            err_nx;
    logic            issue;
    logic [CW-1:0]   cnt_nx;

    always_comb begin
        // Issues arriving while blocked are dropped entirely.
        issue    = issue_valid_i && (state == IDLE);
        lk_nx    = lk;
        state_nx = state;
        mem_nx   = mem_busy_o;
        err_nx   = err_o;

        if (issue_valid_i && (state == BLOCKED))
            err_nx = 1'b1;

        if (issue)
            lk_nx = lk_nx | issue_locks_i;

        // A same-cycle producer keeps its lock; release checks use the pre-update lk.
        for (int unsigned p = 0; p < NWB; p++) begin
            if (wb_valid_i[p] && (wb_rd_i[p] != '0)) begin
                if (!(issue && issue_locks_i[wb_rd_i[p]])) begin
                    lk_nx[wb_rd_i[p]] = 1'b0;
                    if (!lk[wb_rd_i[p]])
                        err_nx = 1'b1;
                end
            end
        end
        lk_nx[0] = 1'b0;

        if (issue && issue_mem_op_i) begin
            mem_nx = 1'b1;
        end else if (mem_done_i) begin
            if (!mem_busy_o)
                err_nx = 1'b1;
            mem_nx = 1'b0;
        end

        case (state)
            IDLE: begin
                if (blk_done_i)
                    err_nx = 1'b1;
                if (issue && issue_blocking_i)
                    state_nx = BLOCKED;
            end
            BLOCKED: begin
                if (blk_done_i)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase

        if (flush_i) begin
            lk_nx    = '0;
            mem_nx   = 1'b0;
            state_nx = IDLE;
            err_nx   = err_o;
        end

        cnt_nx = '0;
        for (int unsigned i = 0; i < NR; i++)
            cnt_nx = cnt_nx + CW'(lk_nx[i]);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            lk         <= '0;
            locks_o    <= '0;
            mem_busy_o <= 1'b0;
            blocked_o  <= 1'b0;
            lock_cnt_o <= '0;
            err_o      <= 1'b0;
        end else begin
            state      <= state_nx;
            lk         <= lk_nx;
            locks_o    <= (state_nx == BLOCKED) ? '1 : lk_nx;
            mem_busy_o <= mem_nx;
            blocked_o  <= (state_nx == BLOCKED);
            lock_cnt_o <= cnt_nx;
            err_o      <= err_nx;
        end
    end

endmodule

// File: tb/tb_reg_lock_tracker.sv
// Directed bench for reg_lock_tracker: hand-computed expectations checked with immediate assertions.
module tb_reg_lock_tracker;

    localparam int unsigned NR  = 64;
    localparam int unsigned NWB = 2;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  issue_valid;
    logic [NR-1:0]         issue_locks;
    logic                  issue_mem_op;
    logic                  issue_blocking;
    logic [NWB-1:0]        wb_valid;
    logic [NWB-1:0][5:0]   wb_rd;
    logic                  mem_done;
    logic                  blk_done;
    logic                  flush;
    logic [NR-1:0]         locks;
    logic                  mem_busy;
    logic                  blocked;
    logic [6:0]            lock_cnt;
    logic                  err;

    int vectors    = 0;
    int miscompares = 0;

    reg_lock_tracker #(.NR(NR), .NWB(NWB)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .issue_valid_i    (issue_valid),
        .issue_locks_i    (issue_locks),
        .issue_mem_op_i   (issue_mem_op),
        .issue_blocking_i (issue_blocking),
        .wb_valid_i       (wb_valid),
        .wb_rd_i          (wb_rd),
        .mem_done_i       (mem_done),
        .blk_done_i       (blk_done),
        .flush_i          (flush),
        .locks_o          (locks),
        .mem_busy_o       (mem_busy),
        .blocked_o        (blocked),
        .lock_cnt_o       (lock_cnt),
        .err_o            (err)
    );

    always #5 clk = ~clk;

    task automatic clear();
        rst            = 1'b0;
        issue_valid    = 1'b0;
        issue_locks    = '0;
        issue_mem_op   = 1'b0;
        issue_blocking = 1'b0;
        wb_valid       = '0;
        wb_rd          = '0;
        mem_done       = 1'b0;
        blk_done       = 1'b0;
        flush          = 1'b0;
    endtask

    // Apply the currently driven inputs for one edge, then return them to idle.
    task automatic tick();
        @(posedge clk);
        #1;
        clear();
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        clear();
        rst = 1'b1;
        tick();
    endtask

    initial begin
        clear();
        rst = 1'b1;
        @(posedge clk); #1;
        tick();

        chk("rst_locks", locks, 64'h0);
        chk("rst_mem", {63'h0, mem_busy}, 64'h0);
        chk("rst_blocked", {63'h0, blocked}, 64'h0);
        chk("rst_cnt", {57'h0, lock_cnt}, 64'h0);
        chk("rst_err", {63'h0, err}, 64'h0);

        // Issue r4,r5 plus r0; r0 must never lock.
        issue_valid = 1'b1; issue_locks = 64'h31;
        tick();
        chk("issue_locks", locks, 64'h30);
        chk("issue_cnt", {57'h0, lock_cnt}, 64'd2);

        wb_valid = 2'b01; wb_rd[0] = 6'd4;
        tick();
        chk("wb4_locks", locks, 64'h20);
        chk("wb4_cnt", {57'h0, lock_cnt}, 64'd1);
        chk("wb4_err", {63'h0, err}, 64'h0);

        issue_valid = 1'b1; issue_locks = 64'h10;
        tick();
        chk("relock4", locks, 64'h30);

        // New producer of r5 wins over port0 release of r5; port1 releases r4.
        issue_valid = 1'b1; issue_locks = 64'h20;
        wb_valid = 2'b11; wb_rd[0] = 6'd5; wb_rd[1] = 6'd4;
        tick();
        chk("race_locks", locks, 64'h20);
        chk("race_err", {63'h0, err}, 64'h0);

        issue_valid = 1'b1; issue_locks = 64'h100;
        tick();
        chk("lock8", locks, 64'h120);
        wb_valid = 2'b11; wb_rd[0] = 6'd8; wb_rd[1] = 6'd8;
        tick();
        chk("dualwb_locks", locks, 64'h20);
        chk("dualwb_cnt", {57'h0, lock_cnt}, 64'd1);
        chk("dualwb_err", {63'h0, err}, 64'h0);

        wb_valid = 2'b01; wb_rd[0] = 6'd0;
        tick();
        chk("wb0_locks", locks, 64'h20);
        chk("wb0_err", {63'h0, err}, 64'h0);

        issue_valid = 1'b1; issue_mem_op = 1'b1;
        tick();
        chk("mem_set", {63'h0, mem_busy}, 64'h1);
        issue_valid = 1'b1; issue_mem_op = 1'b1; mem_done = 1'b1;
        tick();
        chk("mem_setclr", {63'h0, mem_busy}, 64'h1);
        mem_done = 1'b1;
        tick();
        chk("mem_clr", {63'h0, mem_busy}, 64'h0);
        chk("mem_clr_err", {63'h0, err}, 64'h0);

        // Blocking issue of r3: lk becomes 0x28 underneath the all-ones override.
        issue_valid = 1'b1; issue_blocking = 1'b1; issue_locks = 64'h8;
        tick();
        chk("blk_locks", locks, ONES);
        chk("blk_flag", {63'h0, blocked}, 64'h1);
        chk("blk_cnt", {57'h0, lock_cnt}, 64'd2);
        wb_valid = 2'b01; wb_rd[0] = 6'd3;
        tick();
        chk("blk_wb_locks", locks, ONES);
        chk("blk_wb_cnt", {57'h0, lock_cnt}, 64'd1);
        blk_done = 1'b1;
        tick();
        chk("unblk_locks", locks, 64'h20);
        chk("unblk_flag", {63'h0, blocked}, 64'h0);
        chk("unblk_err", {63'h0, err}, 64'h0);

        mem_done = 1'b1;
        tick();
        chk("xtra_done_err", {63'h0, err}, 64'h1);
        chk("xtra_done_mem", {63'h0, mem_busy}, 64'h0);
        do_reset();
        chk("rst_clr_err", {63'h0, err}, 64'h0);

        wb_valid = 2'b01; wb_rd[0] = 6'd7;
        tick();
        chk("wb7_locks", locks, 64'h0);
        chk("wb7_err", {63'h0, err}, 64'h1);
        do_reset();

        blk_done = 1'b1;
        tick();
        chk("idle_blkdone_err", {63'h0, err}, 64'h1);
        chk("idle_blkdone_state", {63'h0, blocked}, 64'h0);
        do_reset();

        issue_valid = 1'b1; issue_blocking = 1'b1;
        tick();
        issue_valid = 1'b1; issue_locks = 64'h40; issue_mem_op = 1'b1;
        tick();
        chk("blk_issue_err", {63'h0, err}, 64'h1);
        chk("blk_issue_cnt", {57'h0, lock_cnt}, 64'd0);
        chk("blk_issue_mem", {63'h0, mem_busy}, 64'h0);
        blk_done = 1'b1;
        tick();
        chk("blk_issue_locks", locks, 64'h0);
        chk("err_sticky", {63'h0, err}, 64'h1);

        // Ten locks (r1..r10), memory busy, then blocked; flush with junk inputs alongside.
        issue_valid = 1'b1; issue_locks = 64'h7FE; issue_mem_op = 1'b1;
        tick();
        chk("ten_cnt", {57'h0, lock_cnt}, 64'd10);
        issue_valid = 1'b1; issue_blocking = 1'b1;
        tick();
        chk("ten_blocked", {63'h0, blocked}, 64'h1);
        chk("ten_mem", {63'h0, mem_busy}, 64'h1);
        flush = 1'b1; issue_valid = 1'b1; issue_locks = 64'h1000;
        wb_valid = 2'b01; wb_rd[0] = 6'd20; mem_done = 1'b1; blk_done = 1'b1;
        tick();
        chk("flush_locks", locks, 64'h0);
        chk("flush_mem", {63'h0, mem_busy}, 64'h0);
        chk("flush_blocked", {63'h0, blocked}, 64'h0);
        chk("flush_cnt", {57'h0, lock_cnt}, 64'd0);
        chk("flush_err", {63'h0, err}, 64'h1);

        flush = 1'b1; issue_valid = 1'b1; issue_locks = 64'hF0; issue_mem_op = 1'b1;
        tick();
        chk("flush_drop_issue", locks, 64'h0);
        chk("flush_drop_mem", {63'h0, mem_busy}, 64'h0);

        issue_valid = 1'b1; issue_locks = 64'hF0; issue_mem_op = 1'b1;
        tick();
        chk("pre_rst_locks", locks, 64'hF0);
        issue_valid = 1'b1; issue_blocking = 1'b1;
        tick();
        do_reset();
        chk("midrst_locks", locks, 64'h0);
        chk("midrst_mem", {63'h0, mem_busy}, 64'h0);
        chk("midrst_blocked", {63'h0, blocked}, 64'h0);
        chk("midrst_cnt", {57'h0, lock_cnt}, 64'd0);
        chk("midrst_err", {63'h0, err}, 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/reg_lock_tracker.md
Name: reg_lock_tracker

Overview:
- Register-lock scoreboard on the release side of the issue-lock handshake.
- Holds the live per-register lock vector and memory-busy flag that feed the register grant checker's locks_i/mem_busy_i.
- Accepts the checker's updated lock vector when an instruction issues, and releases locks as results write back.
- Handles blocking (fence-like) instructions and pipeline flush.

Parameters:
- NR, 64, number of architectural registers (set from maverickOne_pkg::NUM_REGS); power of two, >= 4.
- NWB, 2, number of independent writeback ports.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- issue_valid_i  in  1  instruction issued this cycle (grant checker arb_req_o AND arbiter grant).
- issue_locks_i  in  NR  lock vector produced by the grant checker for the issuing instruction.
- issue_mem_op_i  in  1  issuing instruction is a memory operation.
- issue_blocking_i  in  1  issuing instruction is blocking.
- wb_valid_i  in  NWB  per-port writeback strobe.
- wb_rd_i  in  NWB x $clog2(NR)  per-port destination register index being written back.
- mem_done_i  in  1  outstanding memory operation completed.
- blk_done_i  in  1  blocking instruction retired.
- flush_i  in  1  pipeline flush; discard all locks.
- locks_o  out  NR  current lock vector to grant checker locks_i.
- mem_busy_o  out  1  memory busy flag to grant checker mem_busy_i.
- blocked_o  out  1  tracker is in BLOCKED state.
- lock_cnt_o  out  $clog2(NR)+1  population count of the internal lock register.
- err_o  out  1  sticky protocol error.

Behaviour:
- All outputs are registered; reset value of every output is 0. State resets to IDLE.
- Internal register lk[NR-1:0] is updated each cycle as follows:
  - next = lk;
  - if issue_valid_i: next |= issue_locks_i;
  - for each port p with wb_valid_i[p] and wb_rd_i[p] != 0: clear next[wb_rd_i[p]] unless issue_valid_i && issue_locks_i[wb_rd_i[p]] (a new producer wins over a same-cycle release).
  - next[0] = 0 always.
- Latency: issue or writeback effects are visible on locks_o exactly one cycle later. There is no combinational input-to-output path.
- Two wb ports targeting the same register in one cycle: the bit is cleared once; this is not an error.
- State machine:
  - IDLE: locks_o = lk. issue_valid_i && issue_blocking_i -> BLOCKED.
  - BLOCKED: locks_o = all ones (bit 0 included); blocked_o = 1. Writebacks still clear lk underneath. blk_done_i -> IDLE, and locks_o = lk from the next cycle.
  - issue_valid_i while in BLOCKED: ignored (lk and mem_busy unchanged), err_o set.
  - blk_done_i while in IDLE: err_o set, no state change.
- mem_busy:
  - Set on issue_valid_i && issue_mem_op_i; cleared on mem_done_i.
  - Simultaneous set and clear: set wins, so busy stays 1.
  - mem_done_i while not busy and no same-cycle set: err_o set.
- err_o is also set when wb_valid_i[p] names a nonzero register whose lk bit is 0 and no same-cycle issue sets it.
- err_o is sticky; it is cleared only by rst_i (flush does not clear it).
- flush_i (priority above every other input except rst_i):
  - next cycle: lk = 0, mem_busy_o = 0, state IDLE, lock_cnt_o = 0.
  - all other same-cycle inputs are discarded.
- lock_cnt_o = popcount(next lk) registered alongside lk. It is unaffected by the BLOCKED override, ranges 0..NR-1, and has no wrap.
- Reset mid-operation (any state, with pending locks): all state returns to reset values next cycle.

Test Plan:
- Reset then issue_valid_i=1, issue_locks_i=0x...0030 -> next cycle locks_o=0x30, lock_cnt_o=2; wb_valid_i=01, wb_rd_i[0]=4 -> locks_o=0x20, lock_cnt_o=1, err_o=0.
- Same cycle: issue locks bit 5, port0 writes back r5, port1 writes back r4 (locked) -> locks_o bit5=1, bit4=0, err_o=0.
- Issue blocking with issue_locks_i=0x8 -> locks_o=all ones, blocked_o=1. A writeback of r3 keeps locks_o=all ones. blk_done_i -> locks_o=0, blocked_o=0. A second issue while BLOCKED -> err_o=1 and stays 1.
- Issue mem op -> mem_busy_o=1. Second mem issue concurrent with mem_done_i -> mem_busy_o stays 1. mem_done_i -> 0. Extra mem_done_i -> err_o=1.
- With 10 locks held, BLOCKED and mem busy, assert flush_i -> next cycle locks_o=0, mem_busy_o=0, blocked_o=0, lock_cnt_o=0, err_o unchanged.
- Writeback to r0 or to an unlocked r7 -> locks_o unchanged. r0 gives err_o=0; r7 gives err_o=1.
